// File: rtl/kf_hub_pkg.sv
// kf_hub_pkg -- shared types and helpers for the SPI sniffer / Kalman hub.
//
// Contents:
//   state_e    : hub FSM states (IDLE, SHIFT, FILTER)
//   kf_ch_w()  : width of a channel index for a given channel count (min 1)
//   kf_diff_t  : signed difference type for the innovation z - x
//
// kf_diff_t carries KF_MAX_DATA_W+1 bits. For any DATA_W up to
// KF_MAX_DATA_W, both operands are sign-extended into it, so the
// difference, the arithmetic shift and the update behave exactly as they
// would in a DATA_W+1 bit signed type.
package kf_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FILTER = 2'd2
  } state_e;

  localparam int KF_MAX_DATA_W = 32;

  typedef logic signed [KF_MAX_DATA_W:0] kf_diff_t;

  function automatic int kf_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/spi_sniff_rx.sv
// spi_sniff_rx -- passive SPI mode-0 receiver for the Kalman hub.
//
// Synchronises sck/cs/miso into the clk domain, detects sck rising and cs
// falling/rising edges, and shifts miso in MSB first while a frame is open.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   sck, cs, miso: raw asynchronous SPI lines (cs active-low)
//   cs_fall      : one-cycle pulse, frame start
//   cs_rise      : one-cycle pulse, frame end
//   word         : assembled word, meaningful while word_valid is high
//   word_valid   : one-cycle pulse, DATA_W bits received
//   abort        : one-cycle pulse, frame closed with a partial word
//
// The cs synchroniser resets to 0 (asserted). If reset hits mid-frame with
// cs still low no edge is seen, so bits are ignored until cs has gone high
// and then low again. An idle-high cs only produces a harmless rise.
module spi_sniff_rx
  import kf_hub_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              miso,
  output logic              cs_fall,
  output logic              cs_rise,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              abort
);

  localparam int BIT_W = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   in_frame_q, in_frame_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]      shift_q, shift_d;

  logic sck_s, cs_s, miso_s, sck_rise;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], miso};

    sck_s  = sck_sync_q[SYNC_STAGES-1];
    cs_s   = cs_sync_q[SYNC_STAGES-1];
    miso_s = miso_sync_q[SYNC_STAGES-1];

    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;

    sck_rise = sck_s & ~sck_prev_q;
    cs_fall  = cs_prev_q & ~cs_s;
    cs_rise  = ~cs_prev_q & cs_s;

    // miso travels through the same number of stages as sck, so the
    // synchronised data bit lines up with the synchronised clock edge.
    word       = {shift_q, miso_s};
    word_valid = 1'b0;
    abort      = 1'b0;
    in_frame_d = in_frame_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;

    if (cs_fall) begin
      in_frame_d = 1'b1;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if (cs_rise) begin
      in_frame_d = 1'b0;
      bit_cnt_d  = '0;
      abort      = in_frame_q && (bit_cnt_q != '0);
    end else if (in_frame_q && sck_rise) begin
      shift_d = word[DATA_W-2:0];
      if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
        word_valid = 1'b1;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      miso_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      in_frame_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      miso_sync_q <= miso_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      in_frame_q  <= in_frame_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
    end
  end

endmodule

// File: rtl/spi_sniff_kalman_hub.sv
// spi_sniff_kalman_hub -- sniffs an RP2350 SPI sensor bus and runs a
// steady-state scalar Kalman filter (gain 2^-GAIN_SHIFT) per channel.
//
// Each CS frame carries up to NUM_CH signed DATA_W-bit words; word i updates
// channel i. Every filtered estimate is offered on a valid/ready output.
//
// Ports:
//   clk, rst                  : system clock, synchronous active-high reset
//   rp2350_sck/cs/miso        : sniffed SPI lines (asynchronous, cs active-low)
//   out_data, out_ch          : filtered estimate and its channel
//   out_valid, out_ready      : output handshake
//   frame_err                 : sticky, partial word or too many words
//   ovf_err                   : sticky, result dropped while output full
//   err_clr                   : pulse clearing both sticky flags
//   dbg_state                 : current FSM state
//
// Optional build macro KF_FIRST_SAMPLE_INIT_EN: a channel's first word after
// reset loads the state directly instead of filtering from 0.
//
// Handshake: out_valid/out_data/out_ch stay stable until a cycle with
// out_valid && out_ready; that cycle is the transfer. A result finishing in
// a transfer cycle replaces the outgoing one; a result finishing while
// out_valid && !out_ready is dropped and flags ovf_err.
module spi_sniff_kalman_hub
  import kf_hub_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 3,
  parameter int GAIN_SHIFT  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rp2350_sck,
  input  logic                       rp2350_cs,
  input  logic                       rp2350_miso,
  output logic [DATA_W-1:0]          out_data,
  output logic [kf_ch_w(NUM_CH)-1:0] out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_err,
  output logic                       ovf_err,
  input  logic                       err_clr,
  output state_e                     dbg_state
);

  localparam int              CH_W    = kf_ch_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic              cs_fall, cs_rise, word_valid, abort;
  logic [DATA_W-1:0] word;

  spi_sniff_rx #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .sck       (rp2350_sck),
    .cs        (rp2350_cs),
    .miso      (rp2350_miso),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .word      (word),
    .word_valid(word_valid),
    .abort     (abort)
  );

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
  // Set once the last channel of the frame has been filtered; any further
  // word in the same frame is an excess word.
  logic                     frame_full_q, frame_full_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [DATA_W-1:0] x_q [NUM_CH];
  logic signed [DATA_W-1:0] x_d [NUM_CH];
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     ovf_err_q, ovf_err_d;
`ifdef KF_FIRST_SAMPLE_INIT_EN
  logic [NUM_CH-1:0]        primed_q, primed_d;
`endif

  logic signed [DATA_W-1:0] x_cur, x_new;
  kf_diff_t                 diff;
  logic                     frame_evt, ovf_evt;

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    frame_full_d = frame_full_q;
    z_d          = z_q;
    x_d          = x_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = frame_err_q;
    ovf_err_d    = ovf_err_q;
    frame_evt    = abort;
    ovf_evt      = 1'b0;
`ifdef KF_FIRST_SAMPLE_INIT_EN
    primed_d     = primed_q;
`endif

    // x + ((z - x) >>> K): the arithmetic shift floors toward -inf and the
    // result always lies between x and z, so the truncation cannot wrap.
    x_cur = x_q[ch_idx_q];
    diff  = kf_diff_t'(z_q) - kf_diff_t'(x_cur);
    x_new = DATA_W'(kf_diff_t'(x_cur) + (diff >>> GAIN_SHIFT));
`ifdef KF_FIRST_SAMPLE_INIT_EN
    if (!primed_q[ch_idx_q]) begin
      x_new = z_q;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (word_valid) begin
          if (frame_full_q) begin
            frame_evt = 1'b1;
          end else begin
            z_d     = word;
            state_d = ST_FILTER;
          end
        end
      end
      ST_FILTER: begin
        x_d[ch_idx_q] = x_new;
`ifdef KF_FIRST_SAMPLE_INIT_EN
        primed_d[ch_idx_q] = 1'b1;
`endif
        if (ch_idx_q == LAST_CH) begin
          frame_full_d = 1'b1;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
        end
        state_d = ST_SHIFT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame edges override whatever the state decided.
    if (cs_rise) begin
      state_d = ST_IDLE;
    end
    if (cs_fall) begin
      state_d      = ST_SHIFT;
      ch_idx_d     = '0;
      frame_full_d = 1'b0;
    end

    if (state_q == ST_FILTER) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = x_new;
        out_ch_d    = ch_idx_q;
        out_valid_d = 1'b1;
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first so a coincident error event wins.
    if (err_clr) begin
      frame_err_d = 1'b0;
      ovf_err_d   = 1'b0;
    end
    if (frame_evt) begin
      frame_err_d = 1'b1;
    end
    if (ovf_evt) begin
      ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_idx_q     <= '0;
      frame_full_q <= 1'b0;
      z_q          <= '0;
      x_q          <= '{default: '0};
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
`ifdef KF_FIRST_SAMPLE_INIT_EN
      primed_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      frame_full_q <= frame_full_d;
      z_q          <= z_d;
      x_q          <= x_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      ovf_err_q    <= ovf_err_d;
`ifdef KF_FIRST_SAMPLE_INIT_EN
      primed_q     <= primed_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_sniff_kalman_hub.sv
// Bench for spi_sniff_kalman_hub: SPI frames driven bit by bit, filtered
// results collected from the output handshake and compared against a
// floor-division model of the filter.
module tb_spi_sniff_kalman_hub;
  import kf_hub_pkg::*;

  localparam int DATA_W      = 16;
  localparam int NUM_CH      = 3;
  localparam int GAIN_SHIFT  = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CH_W        = kf_ch_w(NUM_CH);
  localparam int EXP_W       = CH_W + DATA_W;
`ifdef KF_FIRST_SAMPLE_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0, cs = 1'b1, miso = 1'b0;
  logic out_ready = 1'b1, err_clr = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid, frame_err, ovf_err;
  state_e            dbg_state;

  always #5 clk = ~clk;

  spi_sniff_kalman_hub #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAIN_SHIFT(GAIN_SHIFT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .rp2350_sck(sck), .rp2350_cs(cs), .rp2350_miso(miso),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .ovf_err(ovf_err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] got_q[$];
  int x_m[NUM_CH];
  bit primed_m[NUM_CH];

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_ch, out_data});
  end

  function automatic int floor_div_k(input int d);
    int k;
    k = 1 << GAIN_SHIFT;
    return (d >= 0) ? d / k : -((-d + k - 1) / k);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      x_m[i] = 0;
      primed_m[i] = 1'b0;
    end
  endtask

  task automatic model_word(input int ch, input logic [DATA_W-1:0] w, input bit emit);
    logic signed [DATA_W-1:0] ws;
    int z;
    ws = w;
    z  = ws;
    if (INIT_EN && !primed_m[ch]) x_m[ch] = z;
    else x_m[ch] = x_m[ch] + floor_div_k(z - x_m[ch]);
    primed_m[ch] = 1'b1;
    if (emit) exp_q.push_back({CH_W'(ch), DATA_W'(x_m[ch])});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; sck = 1'b0; miso = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    model_reset();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic drive_cs(input logic v);
    @(posedge clk); #2;
    cs = v; sck = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic drive_bits(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      sck = 1'b0; miso = w[DATA_W-1-i];
      repeat (2) @(posedge clk);
      #2 sck = 1'b1;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] words[$]);
    drive_cs(1'b0);
    foreach (words[i]) begin
      drive_bits(words[i], DATA_W);
      if (i < NUM_CH) model_word(i, words[i], 1'b1);
    end
    repeat (6) @(posedge clk);
    drive_cs(1'b1);
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cs = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_out_ch: got %h expected 0", out_ch); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_single_word();
    logic [DATA_W-1:0] w;
    logic [EXP_W-1:0] e;
    w = 16'h0100;
    do_reset();
    model_word(0, w, 1'b1);
    e = exp_q[0];
    drive_cs(1'b0);
    drive_bits(w, DATA_W - 1);
    @(posedge clk); #2;
    sck = 1'b0; miso = w[0];
    repeat (2) @(posedge clk);
    #2 sck = 1'b1;
    // two synchroniser stages, then FILTER, then the output register
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid got %b expected 0", out_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: out_valid got %b expected 1", out_valid); end
    checks++; if (out_data !== e[DATA_W-1:0]) begin errors++; $display("FAIL single_data: got %h expected %h", out_data, e[DATA_W-1:0]); end
    checks++; if (out_ch !== e[EXP_W-1:DATA_W]) begin errors++; $display("FAIL single_ch: got %h expected %h", out_ch, e[EXP_W-1:DATA_W]); end
    repeat (4) @(posedge clk);
    drive_cs(1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b expected 0", frame_err); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_negative();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    do_reset();
    wq.push_back(16'hFF00);
    send_frame(wq);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL neg_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL neg_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_frame3();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    do_reset();
    wq.push_back(16'h0100); wq.push_back(16'h0200); wq.push_back(16'h0300);
    send_frame(wq);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame3_frame_err: got %b expected 0", frame_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame3_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL frame3_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w0, w1;
    logic [EXP_W-1:0] e, g;
    w0 = DATA_W'($urandom); w1 = DATA_W'($urandom);
    @(posedge clk); #2 out_ready = 1'b0;
    drive_cs(1'b0);
    drive_bits(w0, DATA_W); model_word(0, w0, 1'b1);
    drive_bits(w1, DATA_W); model_word(1, w1, 1'b0);
    repeat (6) @(posedge clk);
    drive_cs(1'b1);
    e = exp_q[0];
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_held_valid: got %b expected 1", out_valid); end
    checks++; if ({out_ch, out_data} !== e) begin errors++; $display("FAIL ovf_held_data: got %h expected %h", {out_ch, out_data}, e); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_err); end
    pulse_err_clr();
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_err); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_still_valid: got %b expected 1", out_valid); end
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: out_valid got %b expected 0", out_valid); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ovf_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_partial();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    drive_cs(1'b0);
    drive_bits(16'hABCD, 9);
    drive_cs(1'b1);
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL partial_frame_err: got %b expected 1", frame_err); end
    checks++; if (out_valid !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL partial_no_output: out_valid %b results %0d expected 0", out_valid, got_q.size()); end
    pulse_err_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL partial_clear: got %b expected 0", frame_err); end
    // channel 1 was updated during the overflow test although its result was dropped
    wq.push_back(16'h1234); wq.push_back(16'h8000);
    send_frame(wq);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL partial_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL partial_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_excess();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    for (int i = 0; i < NUM_CH + 1; i++) wq.push_back(DATA_W'($urandom));
    send_frame(wq);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL excess_frame_err: got %b expected 1", frame_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL excess_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL excess_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    pulse_err_clr();
  endtask

  task automatic test_rst_mid();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    drive_cs(1'b0);
    drive_bits(16'hFFFF, 7);
    do_reset();
    @(negedge clk);
    checks++; if ({out_data, out_ch, out_valid, frame_err, ovf_err} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got data %h ch %h valid %b ferr %b oerr %b expected all 0",
                         out_data, out_ch, out_valid, frame_err, ovf_err);
    end
    drive_bits(16'hFFFF, 9);
    drive_bits(16'h5555, DATA_W);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL rstmid_ignored: out_valid %b results %0d expected 0", out_valid, got_q.size()); end
    drive_cs(1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err); end
    wq.push_back(16'h0100);
    send_frame(wq);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rstmid_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] wq[$];
    logic [EXP_W-1:0] e, g;
    int n;
    for (int f = 0; f < 12; f++) begin
      wq.delete();
      n = $urandom_range(1, NUM_CH + 1);
      for (int i = 0; i < n; i++) wq.push_back(DATA_W'($urandom));
      send_frame(wq);
      checks++; if (frame_err !== (n > NUM_CH)) begin errors++; $display("FAIL rand_frame_err: frame %0d got %b expected %b", f, frame_err, n > NUM_CH); end
      pulse_err_clr();
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rand_ovf_err: got %b expected 0", ovf_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rand_result: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_negative();
    test_frame3();
    test_overflow();
    test_partial();
    test_excess();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
